// File: rtl/psum_accum_quant.sv
// Post-MAC partial-sum accumulator and quantizer.
// Accumulates per-lane partial sums across input-channel tiles, then adds the
// per-lane bias, applies a rounding arithmetic right shift and optional ReLU,
// and saturates each lane to an 8-bit activation. Two register stages follow
// the accumulator: stage 1 holds the final sum, stage 2 holds oOut/oVld.
module psum_accum_quant #(
  parameter int NUM_LANE = 48,
  parameter int IN_W     = 20,
  parameter int ACC_W    = 28,
  parameter int BIAS_W   = 16,
  parameter int OUT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vld_i,
  input  logic                         iLast,
  input  logic [NUM_LANE*IN_W-1:0]     iPsum,
  input  logic [NUM_LANE*BIAS_W-1:0]   iBias,
  input  logic [4:0]                   iShift,
  input  logic                         iRelu,
  output logic [NUM_LANE*OUT_W-1:0]    oOut,
  output logic                         oVld,
  output logic                         oErr
);

  // One guard bit above the accumulator catches any single add overflowing.
  localparam int SW = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [SW-1:0]    Q_ZERO  = '0;
  localparam logic signed [SW-1:0]    Q_ONE   = SW'(1);
  localparam logic signed [SW-1:0]    U_MAX   = SW'((2**OUT_W) - 1);
  localparam logic signed [SW-1:0]    S_MAX   = SW'((2**(OUT_W-1)) - 1);
  localparam logic signed [SW-1:0]    S_MIN   = ~S_MAX;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc    [NUM_LANE];
  logic signed [ACC_W-1:0] nxt    [NUM_LANE];
  logic signed [ACC_W-1:0] s1_sum [NUM_LANE];
  logic [NUM_LANE*BIAS_W-1:0] s1_bias;
  logic [4:0]              s1_shift;
  logic                    s1_relu;
  logic                    s1_vld;
  logic [NUM_LANE-1:0]     acc_ovf;
  logic [NUM_LANE-1:0]     bias_ovf;
  logic [NUM_LANE*OUT_W-1:0] q_out;

  // Clamp a guard-bit-wide value back into the accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SW-1:0] v);
    if (v[SW-1] != v[SW-2]) return v[SW-1] ? ACC_MIN : ACC_MAX;
    return v[ACC_W-1:0];
  endfunction

  // Map a shifted value to the unsigned ReLU range or the signed output range.
  function automatic logic [OUT_W-1:0] quant(input logic signed [SW-1:0] r, input logic relu);
    logic [OUT_W-1:0] q;
    // NOTE: q gets a default before the branches so no path leaves it unassigned.
    q = r[OUT_W-1:0];
    if (relu) begin
      if (r < Q_ZERO)     q = '0;
      else if (r > U_MAX) q = '1;
    end else begin
      if (r < S_MIN)      q = {1'b1, {(OUT_W-1){1'b0}}};
      else if (r > S_MAX) q = {1'b0, {(OUT_W-1){1'b1}}};
    end
    return q;
  endfunction

  for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
    logic signed [IN_W-1:0]   p;
    logic signed [SW-1:0]     acc_sum;
    logic signed [BIAS_W-1:0] b;
    logic signed [SW-1:0]     b_sum;
    logic signed [SW-1:0]     s;
    logic signed [SW-1:0]     rnd_c;
    logic signed [SW-1:0]     r;

    // Accumulate path: a fresh group starts from the sign-extended beat.
    assign p          = iPsum[k*IN_W +: IN_W];
    assign acc_sum    = SW'(acc[k]) + SW'(p);
    assign acc_ovf[k] = acc_sum[SW-1] ^ acc_sum[SW-2];
    assign nxt[k]     = (state == IDLE) ? ACC_W'(p) : sat_acc(acc_sum);

    // Quant path: saturating bias add, round half toward +inf, then clamp.
    assign b           = s1_bias[k*BIAS_W +: BIAS_W];
    assign b_sum       = SW'(s1_sum[k]) + SW'(b);
    assign bias_ovf[k] = b_sum[SW-1] ^ b_sum[SW-2];
    assign s           = SW'(sat_acc(b_sum));
    assign rnd_c       = Q_ONE << (s1_shift - 5'd1);
    assign r           = (s1_shift == 5'd0) ? s : ((s + rnd_c) >>> s1_shift);
    assign q_out[k*OUT_W +: OUT_W] = quant(r, s1_relu);
  end

  // Group FSM and per-lane accumulators; idle cycles hold everything.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      // NOTE: the accumulators are a flop bank, not a RAM, so clearing them
      // in reset is cheap and keeps a discarded partial group from leaking.
      for (int k = 0; k < NUM_LANE; k++) acc[k] <= '0;
    end else if (vld_i) begin
      if (iLast) begin
        state <= IDLE;
      end else begin
        state <= ACC;
        for (int k = 0; k < NUM_LANE; k++) acc[k] <= nxt[k];
      end
    end
  end

  // Stage 1: capture the final group sum with the quant controls of that beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_bias  <= '0;
      s1_shift <= '0;
      s1_relu  <= 1'b0;
      for (int k = 0; k < NUM_LANE; k++) s1_sum[k] <= '0;
    end else begin
      s1_vld <= vld_i & iLast;
      if (vld_i && iLast) begin
        s1_bias  <= iBias;
        s1_shift <= iShift;
        s1_relu  <= iRelu;
        for (int k = 0; k < NUM_LANE; k++) s1_sum[k] <= nxt[k];
      end
    end
  end

  // Stage 2: register the quantized lanes; oOut holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      oVld <= 1'b0;
      oOut <= '0;
    end else begin
      oVld <= s1_vld;
      if (s1_vld) oOut <= q_out;
    end
  end

  // Sticky error: accumulator or bias-add saturation until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      oErr <= 1'b0;
    end else if ((vld_i && state == ACC && |acc_ovf) || (s1_vld && |bias_ovf)) begin
      oErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_accum_quant.sv
// Self-checking bench for psum_accum_quant. Expected output vectors are pushed
// to a scoreboard when the final beat of a group is driven; a monitor pops and
// compares them (value and arrival cycle) whenever oVld is seen.
module tb_psum_accum_quant;

  localparam int NL = 48;
  localparam int IW = 20;
  localparam int BW = 16;
  localparam int OW = 8;
  localparam int PW = NL * IW;
  localparam int QW = NL * OW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld_i = 1'b0;
  logic          iLast = 1'b0;
  logic [PW-1:0] iPsum = '0;
  logic [NL*BW-1:0] iBias = '0;
  logic [4:0]    iShift = '0;
  logic          iRelu = 1'b0;
  logic [QW-1:0] oOut;
  logic          oVld;
  logic          oErr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [QW-1:0] out;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  psum_accum_quant dut (
    .clk(clk), .rst(rst), .vld_i(vld_i), .iLast(iLast), .iPsum(iPsum),
    .iBias(iBias), .iShift(iShift), .iRelu(iRelu),
    .oOut(oOut), .oVld(oVld), .oErr(oErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (oVld) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ovld cyc=%0d oOut=%h", cyc, oOut);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (oOut !== mon_e.out) begin
          errors++;
          $display("FAIL out_value cyc=%0d got=%h exp=%h", cyc, oOut, mon_e.out);
        end
        checks++;
        if (cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL out_latency got_cyc=%0d exp_cyc=%0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint clampl(longint v, longint lo, longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [7:0] model_q(longint fin, longint b, int sh, bit rl);
    longint s, r;
    logic [63:0] rv;
    s = clampl(fin + b, -134217728, 134217727);
    if (sh == 0) r = s;
    else r = (s + (64'sd1 <<< (sh - 1))) >>> sh;
    if (rl) r = clampl(r, 0, 255);
    else    r = clampl(r, -128, 127);
    rv = r;
    return rv[7:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [PW-1:0] p, input logic last);
    @(negedge clk);
    vld_i = 1'b1; iLast = last; iPsum = p;
  endtask

  task automatic idle(input int n, input logic junk_last);
    repeat (n) begin
      @(negedge clk);
      vld_i = 1'b0; iLast = junk_last; iPsum = '1;
    end
  endtask

  // Called right after the last beat is driven, before its sampling edge.
  task automatic push_exp(input logic [QW-1:0] v);
    exp_t e;
    e.out = v;
    e.cyc = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      vld_i = 1'b0; iLast = 1'b0;
      #1;
      if (sb.size() == 0) break;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [PW-1:0] fill_psum(input int v);
    logic [PW-1:0] p;
    for (int k = 0; k < NL; k++) p[k*IW +: IW] = IW'(v);
    return p;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (oOut !== '0)  begin errors++; $display("FAIL reset_oOut got=%h exp=0", oOut); end
    checks++; if (oVld !== 1'b0) begin errors++; $display("FAIL reset_oVld got=%b exp=0", oVld); end
    checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL reset_oErr got=%b exp=0", oErr); end
  endtask

  task automatic test_single_tile();
    logic [PW-1:0] p;
    logic [QW-1:0] e;
    p = '0; p[0 +: IW] = 20'sd100;
    iBias = '0; iBias[0 +: BW] = 16'sd28;
    iShift = 5'd2; iRelu = 1'b1;
    e = '0; e[0 +: OW] = 8'd32;
    drive(p, 1'b1); push_exp(e);
    wait_drain(8);
  endtask

  task automatic test_three_tile();
    logic [PW-1:0] p;
    logic [QW-1:0] e;
    p = '0; p[5*IW +: IW] = 20'sd1000;
    iBias = '0; iShift = 5'd4; iRelu = 1'b1;
    e = '0; e[5*OW +: OW] = 8'd188;
    drive(p, 1'b0);
    drive(p, 1'b0);
    drive(p, 1'b1); push_exp(e);
    wait_drain(8);
  endtask

  task automatic test_saturation_sign();
    logic [PW-1:0] p;
    logic [QW-1:0] e;
    p = '0;
    p[1*IW +: IW] = 20'sd10000;
    p[2*IW +: IW] = -20'sd10000;
    p[3*IW +: IW] = -20'sd6;
    iBias = '0; iShift = 5'd2;
    iRelu = 1'b1;
    e = '0; e[1*OW +: OW] = 8'hff;
    drive(p, 1'b1); push_exp(e);
    wait_drain(8);
    iRelu = 1'b0;
    e = '0; e[1*OW +: OW] = 8'h7f; e[2*OW +: OW] = 8'h80; e[3*OW +: OW] = 8'hff;
    drive(p, 1'b1); push_exp(e);
    wait_drain(8);
  endtask

  task automatic test_back_to_back();
    iBias = '0; iShift = 5'd0; iRelu = 1'b0;
    drive(fill_psum(50), 1'b1); push_exp({NL{8'd50}});
    drive(fill_psum(7), 1'b1);  push_exp({NL{8'd7}});
    wait_drain(8);
    idle(4, 1'b1);
    #1;
    checks++;
    if (oOut !== {NL{8'd7}}) begin errors++; $display("FAIL hold_between_pulses got=%h exp=%h", oOut, {NL{8'd7}}); end
  endtask

  task automatic test_random();
    longint acc_l[NL];
    longint bias_l[NL];
    logic [PW-1:0] p;
    logic [QW-1:0] e;
    int nb, v;
    for (int g = 0; g < 20; g++) begin
      nb = $urandom_range(1, 4);
      for (int k = 0; k < NL; k++) begin
        bias_l[k] = longint'($urandom_range(0, 4000)) - 2000;
        iBias[k*BW +: BW] = BW'(bias_l[k]);
        acc_l[k] = 0;
      end
      iShift = 5'($urandom_range(0, 8));
      iRelu  = 1'($urandom_range(0, 1));
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < NL; k++) begin
          v = int'($urandom_range(0, 6000)) - 3000;
          p[k*IW +: IW] = IW'(v);
          acc_l[k] += v;
        end
        drive(p, b == nb - 1);
        if (b == nb - 1) begin
          for (int k = 0; k < NL; k++) e[k*OW +: OW] = model_q(acc_l[k], bias_l[k], int'(iShift), iRelu);
          push_exp(e);
        end else if ($urandom_range(0, 2) == 0) begin
          idle(1, 1'b1);
        end
      end
      wait_drain(8);
    end
    checks++;
    if (oErr !== 1'b0) begin errors++; $display("FAIL err_before_overflow got=%b exp=0", oErr); end
  endtask

  task automatic test_acc_overflow();
    iBias = '0; iShift = 5'd20; iRelu = 1'b0;
    for (int i = 0; i < 300; i++) drive(fill_psum(524287), 1'b0);
    drive(fill_psum(524287), 1'b1); push_exp({NL{8'h7f}});
    wait_drain(8);
    checks++;
    if (oErr !== 1'b1) begin errors++; $display("FAIL err_after_overflow got=%b exp=1", oErr); end
    idle(5, 1'b0);
    #1;
    checks++;
    if (oErr !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", oErr); end
  endtask

  task automatic test_reset_mid_group();
    iBias = '0; iShift = 5'd0; iRelu = 1'b0;
    drive(fill_psum(400), 1'b0);
    drive(fill_psum(400), 1'b0);
    @(negedge clk);
    vld_i = 1'b0; iLast = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (oErr !== 1'b0) begin errors++; $display("FAIL err_cleared_by_rst got=%b exp=0", oErr); end
    drive(fill_psum(50), 1'b1); push_exp({NL{8'd50}});
    wait_drain(8);
  endtask

  task automatic test_reset_kill();
    iBias = '0; iShift = 5'd0; iRelu = 1'b0;
    drive(fill_psum(9), 1'b1);
    @(negedge clk);
    vld_i = 1'b0; iLast = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (oVld !== 1'b0) begin errors++; $display("FAIL kill_oVld got=%b exp=0", oVld); end
    checks++;
    if (oOut !== '0) begin errors++; $display("FAIL kill_oOut got=%h exp=0", oOut); end
    idle(4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_three_tile();
    test_saturation_sign();
    test_back_to_back();
    test_random();
    test_acc_overflow();
    test_reset_mid_group();
    test_reset_kill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
